vol_controller: RTL and testbench

- Owns the playback volume level and sequences volume writes to the VS1003 SCI_VOL register through the SCI master's req/ack port.
- Takes debounced up/down/mute button levels and supports hold-to-repeat stepping.
- Publishes the current volume word for the LED bar decoder and the SCI transfer fields.
- Sits between the button debouncers and the SCI master in the top level.

---
 rtl/vol_controller.sv | 171 +++++++++++++++++
 tb/tb_vol_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vol_controller.sv
// vol_controller: owns the playback volume level, turns debounced button
// levels into single and hold-to-repeat steps, and sequences SCI_VOL writes
// through the SCI master's req/ack handshake.
module vol_controller #(
   parameter logic [3:0]  DEFAULT_LEVEL = 4'd4,
   parameter int unsigned HOLD_CYCLES   = 32'd25_000_000,
   parameter int unsigned REPEAT_CYCLES = 32'd5_000_000,
   parameter logic [7:0]  SCI_VOL_ADDR  = 8'h0B
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        mute,
   input  logic        sci_ack,
   output logic        sci_req,
   output logic [7:0]  sci_addr,
   output logic [15:0] sci_data,
   output logic [15:0] vol_word,
   output logic        busy
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   // Result of one button's step/repeat evaluation for a cycle.
   typedef struct packed {
      logic        step;
      logic        inh;
      logic [31:0] cnt;
   } rep_t;

   state_t      state_q, state_d;
   logic [3:0]  level_q, level_d;
   logic        pending_q, pending_d;
   logic        req_q, req_d;
   logic        busy_q, busy_d;
   logic [15:0] data_q, data_d;
   logic [15:0] committed_q, committed_d;
   logic        up_prev_q, dn_prev_q;
   logic        up_inh_q, dn_inh_q;
   logic [31:0] up_cnt_q, dn_cnt_q;
   rep_t        up_r_s, dn_r_s;
   logic [15:0] target_s;

   // A button steps on its rising edge, then after HOLD_CYCLES, then every
   // REPEAT_CYCLES. Once both buttons were held together, the survivor is
   // inhibited until it is released, so stepping only resumes on a new edge.
   function automatic rep_t rep_next(input logic btn, input logic prev,
                                     input logic other, input logic inh,
                                     input logic [31:0] cnt);
      rep_t r;
      r.step = 1'b0;
      r.inh  = inh;
      r.cnt  = 32'd0;
      if (btn && other) begin
         r.inh = 1'b1;
      end else if (!btn) begin
         r.inh = 1'b0;
      end else begin
         r.inh = inh;
      end
      if (btn && !other && !inh) begin
         if (!prev) begin
            r.step = 1'b1;
         end else if (cnt + 32'd1 == HOLD_CYCLES) begin
            // Reload so the next hit lands REPEAT_CYCLES later.
            r.step = 1'b1;
            r.cnt  = HOLD_CYCLES - REPEAT_CYCLES;
         end else begin
            r.cnt = cnt + 32'd1;
         end
      end
      return r;
   endfunction

   assign vol_word = {level_q, 4'h0, level_q, 4'h0};
   assign target_s = mute ? 16'hFEFE : vol_word;
   assign sci_req  = req_q;
   assign sci_data = data_q;
   assign sci_addr = SCI_VOL_ADDR;
   assign busy     = busy_q;

   // Next-state logic: button stepping, level saturation and write sequencing.
   always_comb begin
      up_r_s      = rep_next(btn_up, up_prev_q, btn_down, up_inh_q, up_cnt_q);
      dn_r_s      = rep_next(btn_down, dn_prev_q, btn_up, dn_inh_q, dn_cnt_q);
      level_d     = level_q;
      state_d     = state_q;
      pending_d   = pending_q;
      req_d       = req_q;
      busy_d      = busy_q;
      data_d      = data_q;
      committed_d = committed_q;

      if (up_r_s.step && (level_q != 4'd0)) begin
         level_d = level_q - 4'd1;
      end else if (dn_r_s.step && (level_q != 4'd15)) begin
         level_d = level_q + 4'd1;
      end else begin
         level_d = level_q;
      end

      case (state_q)
         ST_IDLE: begin
            // Only the latest target is sampled, so steps taken while a
            // write was in flight collapse into one follow-up write.
            if (pending_q || (target_s != committed_q)) begin
               data_d    = target_s;
               req_d     = 1'b1;
               busy_d    = 1'b1;
               pending_d = 1'b0;
               state_d   = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (sci_ack) begin
               committed_d = data_q;
               req_d       = 1'b0;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_REQ;
            end
         end
         default: begin
            req_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; pending forces a first write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         level_q     <= DEFAULT_LEVEL;
         pending_q   <= 1'b1;
         req_q       <= 1'b0;
         busy_q      <= 1'b0;
         data_q      <= 16'h0000;
         committed_q <= 16'h0000;
         up_prev_q   <= 1'b0;
         dn_prev_q   <= 1'b0;
         up_inh_q    <= 1'b0;
         dn_inh_q    <= 1'b0;
         up_cnt_q    <= 32'd0;
         dn_cnt_q    <= 32'd0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         pending_q   <= pending_d;
         req_q       <= req_d;
         busy_q      <= busy_d;
         data_q      <= data_d;
         committed_q <= committed_d;
         up_prev_q   <= btn_up;
         dn_prev_q   <= btn_down;
         up_inh_q    <= up_r_s.inh;
         dn_inh_q    <= dn_r_s.inh;
         up_cnt_q    <= up_r_s.cnt;
         dn_cnt_q    <= dn_r_s.cnt;
      end
   end

endmodule

// File: tb/tb_vol_controller.sv
// Directed, table-driven bench for vol_controller with short hold/repeat
// parameters so the repeat timing can be observed cycle by cycle.
module tb_vol_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_up = 1'b0;
   logic        btn_down = 1'b0;
   logic        mute = 1'b0;
   logic        sci_ack = 1'b0;
   logic        sci_req;
   logic [7:0]  sci_addr;
   logic [15:0] sci_data;
   logic [15:0] vol_word;
   logic        busy;

   int errors = 0;
   int checks = 0;
   logic auto_ack = 1'b0;

   typedef struct packed {
      logic        up;
      logic        dn;
      logic        mu;
      logic        ack;
      logic [15:0] vol;
      logic        req;
      logic [15:0] data;
   } vec_t;

   vec_t tbl [0:25];
   int   step_at [0:5];

   vol_controller #(
      .DEFAULT_LEVEL(4'd4),
      .HOLD_CYCLES(32'd10),
      .REPEAT_CYCLES(32'd4),
      .SCI_VOL_ADDR(8'h0B)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .mute(mute),
      .sci_ack(sci_ack),
      .sci_req(sci_req),
      .sci_addr(sci_addr),
      .sci_data(sci_data),
      .vol_word(vol_word),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_ack) sci_ack = sci_req;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int lvl;
      //            up    dn    mu    ack   vol       req   data
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h4040, 1'b1, 16'h4040};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h4040, 1'b1, 16'h4040};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h4040, 1'b1, 16'h4040};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4040, 1'b0, 16'h4040};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h4040, 1'b0, 16'h4040};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h4040, 1'b0, 16'h4040};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h5050, 1'b0, 16'h4040};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h5050, 1'b1, 16'h5050};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h5050, 1'b1, 16'h5050};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h5050, 1'b0, 16'h5050};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h5050, 1'b0, 16'h5050};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h4040, 1'b0, 16'h5050};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4040, 1'b1, 16'h4040};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h3030, 1'b0, 16'h4040};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h3030, 1'b1, 16'h3030};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h2020, 1'b0, 16'h3030};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h2020, 1'b1, 16'h2020};
      tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h1010, 1'b0, 16'h2020};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1010, 1'b1, 16'h1010};
      tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h1010};
      tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
      tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
      tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
      tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
      tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
      tbl[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
      step_at = '{0, 10, 14, 18, 22, 26};

      // Reset state
      ticks(2);
      chk("rst_vol", {16'h0, vol_word}, {16'h0, 16'h4040});
      chk("rst_req", {31'h0, sci_req}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_data", {16'h0, sci_data}, 32'h0);
      rst = 1'b0;

      // Init write, single step, saturation at level 0
      for (int i = 0; i < 26; i++) begin
         btn_up   = tbl[i].up;
         btn_down = tbl[i].dn;
         mute     = tbl[i].mu;
         sci_ack  = tbl[i].ack;
         tick();
         chk($sformatf("row%0d_vol", i), {16'h0, vol_word}, {16'h0, tbl[i].vol});
         chk($sformatf("row%0d_req", i), {31'h0, sci_req}, {31'h0, tbl[i].req});
         chk($sformatf("row%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].req});
         chk($sformatf("row%0d_data", i), {16'h0, sci_data}, {16'h0, tbl[i].data});
         chk($sformatf("row%0d_addr", i), {24'h0, sci_addr}, 32'h0B);
      end
      sci_ack = 1'b0;

      // Hold-to-repeat from level 4 with HOLD=10, REPEAT=4
      rst = 1'b1;
      tick();
      chk("rst2_vol", {16'h0, vol_word}, {16'h0, 16'h4040});
      rst = 1'b0;
      auto_ack = 1'b1;
      ticks(6);
      chk("init2_req", {31'h0, sci_req}, 32'h0);
      chk("init2_data", {16'h0, sci_data}, {16'h0, 16'h4040});
      for (int i = 0; i < 30; i++) begin
         btn_down = 1'b1;
         tick();
         lvl = 4;
         for (int s = 0; s < 6; s++) if (step_at[s] <= i) lvl++;
         chk($sformatf("hold%0d_vol", i), {16'h0, vol_word},
             {16'h0, lvl[3:0], 4'h0, lvl[3:0], 4'h0});
      end
      btn_down = 1'b0;
      tick();
      chk("hold_final", {16'h0, vol_word}, {16'h0, 16'hA0A0});

      // Saturation at level 15 via repeat
      btn_down = 1'b1;
      ticks(40);
      chk("sat15_vol", {16'h0, vol_word}, {16'h0, 16'hF0F0});
      btn_down = 1'b0;
      ticks(5);
      auto_ack = 1'b0;
      sci_ack = 1'b0;
      chk("sat15_idle", {31'h0, sci_req}, 32'h0);
      btn_down = 1'b1;
      tick();
      chk("sat15_press", {16'h0, vol_word}, {16'h0, 16'hF0F0});
      btn_down = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("sat15_noreq%0d", i), {31'h0, sci_req}, 32'h0);
      end

      // Both buttons held: no step; survivor stays inhibited until released
      auto_ack = 1'b1;
      btn_up = 1'b1;
      btn_down = 1'b1;
      ticks(12);
      chk("both_vol", {16'h0, vol_word}, {16'h0, 16'hF0F0});
      btn_down = 1'b0;
      ticks(14);
      chk("both_inhibit", {16'h0, vol_word}, {16'h0, 16'hF0F0});
      btn_up = 1'b0;
      tick();

      // Coalescing of steps taken during a busy write
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ticks(5);
      auto_ack = 1'b0;
      sci_ack = 1'b0;
      chk("co_idle", {31'h0, sci_req}, 32'h0);
      btn_down = 1'b1;
      tick();
      chk("co_vol5", {16'h0, vol_word}, {16'h0, 16'h5050});
      btn_down = 1'b0;
      tick();
      chk("co_req", {31'h0, sci_req}, 32'h1);
      chk("co_data", {16'h0, sci_data}, {16'h0, 16'h5050});
      for (int k = 0; k < 3; k++) begin
         btn_down = 1'b1;
         tick();
         chk($sformatf("co_frz%0da", k), {15'h0, sci_req, sci_data}, {15'h0, 1'b1, 16'h5050});
         btn_down = 1'b0;
         tick();
         chk($sformatf("co_frz%0db", k), {15'h0, sci_req, sci_data}, {15'h0, 1'b1, 16'h5050});
      end
      chk("co_vol8", {16'h0, vol_word}, {16'h0, 16'h8080});
      sci_ack = 1'b1;
      tick();
      chk("co_ack", {31'h0, sci_req}, 32'h0);
      sci_ack = 1'b0;
      tick();
      chk("co_req2", {31'h0, sci_req}, 32'h1);
      chk("co_data2", {16'h0, sci_data}, {16'h0, 16'h8080});
      sci_ack = 1'b1;
      tick();
      sci_ack = 1'b0;
      chk("co_done", {31'h0, sci_req}, 32'h0);
      tick();
      chk("co_quiet", {31'h0, sci_req}, 32'h0);

      // Mute, unmute, reset mid-write
      mute = 1'b1;
      tick();
      chk("mute_req", {15'h0, sci_req, sci_data}, {15'h0, 1'b1, 16'hFEFE});
      chk("mute_vol", {16'h0, vol_word}, {16'h0, 16'h8080});
      sci_ack = 1'b1;
      tick();
      sci_ack = 1'b0;
      chk("mute_ack", {31'h0, sci_req}, 32'h0);
      tick();
      chk("mute_quiet", {31'h0, sci_req}, 32'h0);
      mute = 1'b0;
      tick();
      chk("unmute_req", {15'h0, sci_req, sci_data}, {15'h0, 1'b1, 16'h8080});
      rst = 1'b1;
      tick();
      chk("midrst_req", {31'h0, sci_req}, 32'h0);
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      chk("midrst_vol", {16'h0, vol_word}, {16'h0, 16'h4040});
      rst = 1'b0;
      tick();
      chk("midrst_init", {15'h0, sci_req, sci_data}, {15'h0, 1'b1, 16'h4040});
      sci_ack = 1'b1;
      tick();
      sci_ack = 1'b0;
      chk("midrst_done", {31'h0, sci_req}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
